// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer datapath: note word layout, default timing
// and the field decode helpers used by the note player.
package buzzer_pkg;

  localparam int NOTE_BEATS_MSB = 15;
  localparam int NOTE_BEATS_LSB = 12;
  localparam int NOTE_HALF_MSB  = 11;
  localparam int NOTE_HALF_LSB  = 0;

  localparam int DEFAULT_PRESCALE   = 50;
  localparam int DEFAULT_BEAT_TICKS = 6_250_000;

  localparam logic [15:0] NOTE_END = 16'h0000;

  typedef logic [15:0] note_t;

  // A beat field of 0 encodes the longest note, 16 beats.
  function automatic logic [4:0] note_beats(input note_t n);
    logic [3:0] field;
    field = n[NOTE_BEATS_MSB:NOTE_BEATS_LSB];
    return (field == 4'd0) ? 5'd16 : {1'b0, field};
  endfunction

  function automatic logic [11:0] note_half(input note_t n);
    return n[NOTE_HALF_MSB:NOTE_HALF_LSB];
  endfunction

endpackage

// File: rtl/buzzer_tone_gen.sv
// Square-wave tone generator: prescaler ticks advance a half-period counter,
// which toggles pwm each time it reaches the programmed half-period.
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [11:0] half,
  output logic        pwm
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic [11:0]   cnt_q, cnt_d;
  logic          pwm_q, pwm_d;
  logic [12:0]   cnt_inc;

  always_comb begin
    // NOTE: every variable gets its hold value before any branch, so no path leaves it unassigned (no latch).
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    pwm_d   = pwm_q;
    cnt_inc = {1'b0, cnt_q} + 13'd1;
    if (clr || half == 12'd0) begin
      pre_d = '0;
      cnt_d = '0;
      pwm_d = 1'b0;
    end else if (en) begin
      if (pre_q == PW'(PRESCALE - 1)) begin
        pre_d = '0;
        // >= rather than == so a shorter half fetched mid-note still toggles on the next tick.
        if (cnt_inc >= {1'b0, half}) begin
          cnt_d = '0;
          pwm_d = ~pwm_q;
        end else begin
          cnt_d = cnt_inc[11:0];
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/buzzer_note_player.sv
// Note player datapath: latches the DMA note word, drives the buzzer pin through
// the tone generator and times the note length in beats.
module buzzer_note_player
  import buzzer_pkg::*;
#(
  parameter int PRESCALE   = DEFAULT_PRESCALE,
  parameter int BEAT_TICKS = DEFAULT_BEAT_TICKS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch,
  input  logic [15:0] note,
  input  logic        beat_cnt_rstn,
  input  logic        beat_cnt_en,
  input  logic        tune_pwm_rstn,
  input  logic        tune_pwm_en,
  output logic        beat_finish,
  output logic        buzzer
);

  localparam int BW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;

  note_t         note_q, note_d;
  logic [BW-1:0] cyc_q, cyc_d;
  logic [4:0]    beat_idx_q, beat_idx_d;
  logic          beat_finish_q, beat_finish_d;
  logic [4:0]    beat_idx_inc;
  logic [4:0]    nbeats;
  logic          tone_clr;
  logic          pwm;

  assign nbeats   = note_beats(note_q);
  assign tone_clr = ~tune_pwm_rstn;

  always_comb begin
    note_d        = fetch ? note : note_q;
    cyc_d         = cyc_q;
    beat_idx_d    = beat_idx_q;
    beat_finish_d = beat_finish_q;
    beat_idx_inc  = beat_idx_q + 5'd1;
    if (!beat_cnt_rstn) begin
      cyc_d         = '0;
      beat_idx_d    = '0;
      beat_finish_d = 1'b0;
    end else if (beat_cnt_en && !beat_finish_q) begin
      if (cyc_q == BW'(BEAT_TICKS - 1)) begin
        cyc_d      = '0;
        beat_idx_d = beat_idx_inc;
        if (beat_idx_inc >= nbeats) begin
          beat_finish_d = 1'b1;
        end
      end else begin
        cyc_d = cyc_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      note_q        <= '0;
      cyc_q         <= '0;
      beat_idx_q    <= '0;
      beat_finish_q <= 1'b0;
    end else begin
      note_q        <= note_d;
      cyc_q         <= cyc_d;
      beat_idx_q    <= beat_idx_d;
      beat_finish_q <= beat_finish_d;
    end
  end

  buzzer_tone_gen #(
    .PRESCALE (PRESCALE)
  ) u_tone_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (tone_clr),
    .en   (tune_pwm_en),
    .half (note_half(note_q)),
    .pwm  (pwm)
  );

  // Gating with the enable keeps a paused tone from parking DC on the pin.
  assign buzzer      = pwm & tune_pwm_en;
  assign beat_finish = beat_finish_q;

endmodule

// File: doc/buzzer_note_player.md
# buzzer_note_player

Datapath stage directly downstream of the buzzer control FSM. It latches the 16-bit note word delivered by the buzzer DMA on `fetch` and produces the square-wave drive for the buzzer pin. It also times the note's duration in beats and raises `beat_finish` so the controller can fetch the next note. All enables and clears come from the controller; this block makes no sequencing decisions of its own.

## Interface
- `PRESCALE`, default 50: clock cycles per tone tick (1 µs at 50 MHz); ≥1.
- `BEAT_TICKS`, default 6_250_000: enabled clock cycles per beat (125 ms at 50 MHz); ≥1.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high; one clock, the reset is synchronous and active-high.
- `fetch` in 1: load `note` into the note register this cycle.
- `note` in 16: note word from the DMA buffer; [15:12] beat count, [11:0] half-period in tone ticks.
- `beat_cnt_rstn` in 1: synchronous clear of the beat timer and `beat_finish`, active-low.
- `beat_cnt_en` in 1: beat timer advances when high.
- `tune_pwm_rstn` in 1: synchronous clear of the tone generator, active-low.
- `tune_pwm_en` in 1: tone generator advances and drives the pin when high.
- `beat_finish` out 1: registered, sticky; note duration elapsed.
- `buzzer` out 1: buzzer pin drive.

## Operation
- Note register: `note_q` ← `note` when `fetch`; otherwise holds. Reset value 0.
- Beat count: `nbeats` = `note_q[15:12]`, where 0 means 16. Half-period: `half` = `note_q[11:0]`, where 0 means rest.
- Tone generator:
  - Prescaler counts 0..PRESCALE-1 on enabled cycles; wrap = tick.
  - On a tick, the half counter increments. When the incremented value ≥ `half`, it resets to 0 and `pwm_q` toggles.
  - If `half` = 0, `pwm_q` is forced to 0 and the counters hold at 0.
- `buzzer` = `pwm_q & tune_pwm_en`. A paused tone never leaves DC on the pin.
- Beat timer:
  - Cycle counter counts 0..BEAT_TICKS-1 while `beat_cnt_en` is high and `beat_finish` is low; wrap increments the beat index.
  - When the beat index reaches `nbeats` on a wrap, `beat_finish` is set. Counters then freeze until cleared.
- Priority, per counter group: `rst` > clear (`*_rstn` = 0) > enable > hold.
- `fetch` during play: the new `half` applies immediately. The ≥ compare guarantees a toggle at the next tick if the counter already exceeds the new value. `nbeats` is compared live the same way.
- Width rules:
  - Prescaler: $clog2(PRESCALE) bits, min 1.
  - Beat cycle counter: $clog2(BEAT_TICKS) bits, min 1.
  - Half counter: 12 bits. Beat index: 5 bits.
  - No overflow is possible given the ≥ compares.

## Timing
- Reset values: `beat_finish` = 0, `buzzer` = 0, all counters 0, `note_q` = 0.
- `fetch` in cycle N → `note_q` valid in cycle N+1.
- Tone: first toggle of `pwm_q` after `half`×PRESCALE enabled cycles following a clear. Period = 2×`half`×PRESCALE enabled cycles.
- Beat: `beat_finish` rises on the edge that ends the `nbeats`×BEAT_TICKS-th enabled cycle. It is visible the following cycle and stays high until `beat_cnt_rstn` = 0 or `rst`.
- Disabled cycles (pause) are not counted. Total duration extends by exactly the number of disabled cycles.
- Clear with enable in the same cycle: clear wins; counting starts the next cycle.
- `rst` mid-note: all state returns to reset values at the next edge, including `note_q`.

## Structure
- Shared package `buzzer_pkg`:
  - Note field positions: `NOTE_BEATS_MSB/LSB` = 15/12, `NOTE_HALF_MSB/LSB` = 11/0.
  - Default `PRESCALE` and `BEAT_TICKS`.
  - `NOTE_END` = 16'h0000, the terminator also decoded by the controller.
- One sub-module, `buzzer_tone_gen`: prescaler, half counter and `pwm_q` with `clr`, `en` and `half` inputs. The beat timer and note register stay in the top module.

## Test plan
All scenarios use PRESCALE=2, BEAT_TICKS=10.
- Reset: hold `rst` 3 cycles with random inputs → `buzzer` = 0, `beat_finish` = 0, and `note_q` = 0 on release.
- Fetch 16'h3005, then both enables high and both clears high → `buzzer` toggles every 10 cycles (first rise at cycle 10); `beat_finish` rises after 30 enabled cycles and holds.
- Same note, enables dropped for 7 cycles mid-beat → `buzzer` = 0 during the pause; `beat_finish` is delayed by exactly 7 cycles; tone phase resumes unchanged.
- Fetch 16'h2000 (rest) → `buzzer` stays 0 throughout; `beat_finish` after 20 cycles.
- Fetch 16'h0001 → 16 beats: `beat_finish` after 160 cycles; `buzzer` period 4 cycles.
- `rst` pulsed at cycle 15 of 16'h3005 playback → all outputs 0 next cycle; re-fetch then replays with full 30-cycle duration. Also check `beat_cnt_rstn` = 0 clears a set `beat_finish` in one cycle.
